move_btn_conditioner: RTL and testbench



---
 rtl/crossyroad_pkg.sv | 19 +
 rtl/btn_debounce.sv | 49 ++++
 rtl/move_btn_conditioner.sv | 132 +++++++++++++
 tb/tb_move_btn_conditioner.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/crossyroad_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | crossyroad_pkg : shared button FSM state type and 25 MHz timings |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package crossyroad_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } btn_state_t;

  localparam int DEBOUNCE_10MS       = 250000;
  localparam int REPEAT_DELAY_500MS  = 12500000;
  localparam int REPEAT_PERIOD_200MS = 5000000;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btn_debounce : 2-FF synchroniser plus counter-based debouncer    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module btn_debounce
  import crossyroad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn_raw,
  output logic o_btn_level
);

  localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
      // Any agreement restarts the count, so only an unbroken run flips the level
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_DEB_LAST) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_btn_level = r_level;

endmodule
`default_nettype wire

// File: rtl/move_btn_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | move_btn_conditioner : debounced press/auto-repeat step pulses,  |
// | optionally aligned to frame_start. Rev 1.0                       |
// +------------------------------------------------------------------+
module move_btn_conditioner
  import crossyroad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_200MS,
  parameter int FRAME_ALIGN     = 1,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic frame_start,
  output logic move_btn,
  output logic btn_level,
  output logic pending
);

  localparam logic [CNT_W-1:0] c_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam bit               c_REPEAT_EN   = (REPEAT_DELAY != 0);

  logic             w_level;
  logic             w_req;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_rep_cnt;
  logic             r_move;
  logic             r_pending;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .i_btn_raw   (btn_raw),
    .o_btn_level (w_level)
  );

  // Release masks every request, giving it priority over a same-cycle expiry
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      IDLE:        w_req = w_level;
      HELD_DELAY:  w_req = w_level && c_REPEAT_EN && (r_rep_cnt == c_DELAY_LAST);
      HELD_REPEAT: w_req = w_level && (r_rep_cnt == c_PERIOD_LAST);
      default:     w_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_rep_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_level) begin
            r_state   <= HELD_DELAY;
            r_rep_cnt <= '0;
          end
        end
        HELD_DELAY: begin
          if (!w_level) begin
            r_state   <= IDLE;
            r_rep_cnt <= '0;
          end else if (w_req) begin
            r_state   <= HELD_REPEAT;
            r_rep_cnt <= '0;
          end else if (c_REPEAT_EN) begin
            r_rep_cnt <= r_rep_cnt + CNT_W'(1);
          end
        end
        HELD_REPEAT: begin
          if (!w_level) begin
            r_state   <= IDLE;
            r_rep_cnt <= '0;
          end else if (w_req) begin
            r_rep_cnt <= '0;
          end else begin
            r_rep_cnt <= r_rep_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          r_rep_cnt <= '0;
        end
      endcase
    end
  end

  generate
    if (FRAME_ALIGN != 0) begin : g_frame_align
      // One buffered step per frame; extra requests merge into the same slot
      always_ff @(posedge clk) begin
        if (reset) begin
          r_move    <= 1'b0;
          r_pending <= 1'b0;
        end else if (frame_start && (r_pending || w_req)) begin
          r_move    <= 1'b1;
          r_pending <= 1'b0;
        end else begin
          r_move <= 1'b0;
          if (w_req) begin
            r_pending <= 1'b1;
          end
        end
      end
    end else begin : g_direct
      always_ff @(posedge clk) begin
        if (reset) begin
          r_move    <= 1'b0;
          r_pending <= 1'b0;
        end else begin
          r_move    <= w_req && !r_move;
          r_pending <= 1'b0;
        end
      end
    end
  endgenerate

  assign move_btn  = r_move;
  assign btn_level = w_level;
  assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_move_btn_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_move_btn_conditioner : scoreboard bench for three configs     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_move_btn_conditioner;

  logic clk;
  logic reset;
  logic btn0, btn1, btn2;
  logic fs0, fs1, fs2;
  logic mv0, mv1, mv2;
  logic lvl0, lvl1, lvl2;
  logic pnd0, pnd1, pnd2;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int q0[$];
  int q1[$];
  int q2[$];

  // u_dut0: direct output, u_dut1: frame aligned, u_dut2: aligned without repeat
  move_btn_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8),
                         .FRAME_ALIGN(0), .CNT_W(8)) u_dut0 (
    .clk(clk), .reset(reset), .btn_raw(btn0), .frame_start(fs0),
    .move_btn(mv0), .btn_level(lvl0), .pending(pnd0));

  move_btn_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8),
                         .FRAME_ALIGN(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset(reset), .btn_raw(btn1), .frame_start(fs1),
    .move_btn(mv1), .btn_level(lvl1), .pending(pnd1));

  move_btn_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(8),
                         .FRAME_ALIGN(1), .CNT_W(8)) u_dut2 (
    .clk(clk), .reset(reset), .btn_raw(btn2), .frame_start(fs2),
    .move_btn(mv2), .btn_level(lvl2), .pending(pnd2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each observed pulse must match the next expected pulse cycle
  always @(negedge clk) begin
    if (mv0) begin
      if (q0.size() > 0) chk("pulse0", cyc, q0.pop_front());
      else chk("spurious0", cyc, -1);
    end
    if (mv1) begin
      if (q1.size() > 0) chk("pulse1", cyc, q1.pop_front());
      else chk("spurious1", cyc, -1);
    end
    if (mv2) begin
      if (q2.size() > 0) chk("pulse2", cyc, q2.pop_front());
      else chk("spurious2", cyc, -1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    int r;
    int seen;
    logic [4:0] pat;

    reset = 1'b1;
    btn0 = 1'b0; btn1 = 1'b0; btn2 = 1'b0;
    fs0 = 1'b0; fs1 = 1'b0; fs2 = 1'b0;
    wait_cyc(3);
    chk("rst_lvl0", lvl0, 0);
    chk("rst_mv1", mv1, 0);
    chk("rst_pnd1", pnd1, 0);
    chk("rst_pnd2", pnd2, 0);
    reset = 1'b0;
    wait_cyc(2);

    // Clean press, 15-cycle hold
    k0 = cyc;
    q0.push_back(k0 + 7);
    btn0 = 1'b1;
    wait_cyc(5); chk("t1_lvl_e5", lvl0, 0);
    wait_cyc(1); chk("t1_lvl_e6", lvl0, 1);
    wait_cyc(9); btn0 = 1'b0;
    wait_cyc(5); chk("t1_fall_e5", lvl0, 1);
    wait_cyc(1); chk("t1_fall_e6", lvl0, 0);
    wait_cyc(20); chk("t1_missing", q0.size(), 0);

    // Bounce then steady press
    k0 = cyc;
    q0.push_back(k0 + 12);
    pat = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      btn0 = pat[i];
      wait_cyc(1);
    end
    btn0 = 1'b1;
    wait_cyc(15); btn0 = 1'b0;
    wait_cyc(15); chk("t2_missing", q0.size(), 0);

    // Short glitch
    btn0 = 1'b1;
    wait_cyc(3); btn0 = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      wait_cyc(1);
      if (lvl0) seen = 1;
    end
    chk("t2_glitch_lvl", seen, 0);

    // Long hold with auto-repeat
    k0 = cyc;
    q0.push_back(k0 + 7);
    q0.push_back(k0 + 27);
    q0.push_back(k0 + 35);
    q0.push_back(k0 + 43);
    q0.push_back(k0 + 51);
    q0.push_back(k0 + 59);
    btn0 = 1'b1;
    wait_cyc(60); btn0 = 1'b0;
    wait_cyc(5); chk("t3_fall_e5", lvl0, 1);
    wait_cyc(1); chk("t3_fall_e6", lvl0, 0);
    wait_cyc(20); chk("t3_missing", q0.size(), 0);

    // Frame aligned: long wait for frame_start
    k0 = cyc;
    btn1 = 1'b1;
    wait_cyc(6); chk("t4_pnd_e6", pnd1, 0);
    wait_cyc(1); chk("t4_pnd_e7", pnd1, 1);
    wait_cyc(83); btn1 = 1'b0;
    wait_cyc(10); chk("t4_pnd_pre", pnd1, 1);
    q1.push_back(cyc + 1);
    fs1 = 1'b1;
    wait_cyc(1); fs1 = 1'b0;
    chk("t4_pnd_post", pnd1, 0);
    wait_cyc(9); fs1 = 1'b1;
    wait_cyc(1); fs1 = 1'b0;
    wait_cyc(5); chk("t4_missing", q1.size(), 0);

    // No auto-repeat: long hold under regular frames gives one pulse
    k0 = cyc;
    q2.push_back(k0 + 16);
    btn2 = 1'b1;
    for (int i = 0; i < 150; i++) begin
      fs2 = ((i % 16) == 15);
      wait_cyc(1);
    end
    fs2 = 1'b0;
    btn2 = 1'b0;
    wait_cyc(20);
    chk("t4b_missing", q2.size(), 0);
    chk("t4b_pnd_end", pnd2, 0);

    // Request coincident with frame_start, then two merged requests
    k0 = cyc;
    btn1 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      fs1 = (i == 6) || (i == 40) || (i == 50);
      if (i == 30) btn1 = 1'b0;
      if (i == 6) q1.push_back(k0 + 7);
      if (i == 40) q1.push_back(k0 + 41);
      if (i == 7) chk("t5_pnd_e7", pnd1, 0);
      if (i == 8) chk("t5_pnd_e8", pnd1, 0);
      if (i == 27) chk("t5_pnd_e27", pnd1, 1);
      if (i == 40) chk("t5_pnd_e40", pnd1, 1);
      if (i == 41) chk("t5_pnd_e41", pnd1, 0);
      wait_cyc(1);
    end
    fs1 = 1'b0;
    wait_cyc(5); chk("t5_missing", q1.size(), 0);

    // Reset while held and pending
    k0 = cyc;
    q0.push_back(k0 + 7);
    btn0 = 1'b1;
    btn1 = 1'b1;
    wait_cyc(10); chk("t6_pnd_before", pnd1, 1);
    reset = 1'b1;
    wait_cyc(1);
    chk("t6_rst_pnd1", pnd1, 0);
    chk("t6_rst_mv1", mv1, 0);
    chk("t6_rst_mv0", mv0, 0);
    chk("t6_rst_lvl0", lvl0, 0);
    chk("t6_rst_lvl1", lvl1, 0);
    wait_cyc(1); reset = 1'b0;
    r = cyc;
    q0.push_back(r + 7);
    wait_cyc(6); chk("t6_lvl_e6", lvl0, 1);
    wait_cyc(1); chk("t6_pnd_after", pnd1, 1);
    wait_cyc(8); btn0 = 1'b0; btn1 = 1'b0;
    wait_cyc(5);
    q1.push_back(cyc + 1);
    fs1 = 1'b1;
    wait_cyc(1); fs1 = 1'b0;
    wait_cyc(20);
    chk("t6_missing0", q0.size(), 0);
    chk("t6_missing1", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
